// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, SubBytes FSM encoding, byte helpers and the
// FIPS-197 forward S-box.
package aes_pkg;

   localparam int AES_STATE_W   = 128;
   localparam int AES_NUM_BYTES = 16;

   typedef enum logic [1:0] {IDLE, SUB, HOLD} subbytes_state_t;

   // Byte 0 is the most significant byte of the state.
   function automatic logic [7:0] get_byte(input logic [AES_STATE_W-1:0] s, input logic [3:0] i);
      return s[AES_STATE_W-1-8*int'(i) -: 8];
   endfunction

   function automatic logic [AES_STATE_W-1:0] put_byte(input logic [AES_STATE_W-1:0] s,
                                                      input logic [3:0] i,
                                                      input logic [7:0] b);
      logic [AES_STATE_W-1:0] r;
      r = s;
      r[AES_STATE_W-1-8*int'(i) -: 8] = b;
      return r;
   endfunction

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

endpackage

// File: rtl/subbytes_seq_if.sv
// Upstream and downstream handshake bundle for the SubBytes sequencer.
interface subbytes_seq_if
   import aes_pkg::*;
();
   logic                   in_valid;
   logic                   in_ready;
   logic [AES_STATE_W-1:0] in_state;
   logic                   out_valid;
   logic                   out_ready;
   logic [AES_STATE_W-1:0] out_state;
   logic                   busy;

   modport master (
      output in_valid, in_state, out_ready,
      input  in_ready, out_valid, out_state, busy
   );

   modport slave (
      input  in_valid, in_state, out_ready,
      output in_ready, out_valid, out_state, busy
   );
endinterface

// File: rtl/aes_sbox_lut.sv
// Combinational forward S-box lookup for one byte lane.
module aes_sbox_lut
   import aes_pkg::*;
(
   input  logic [7:0] data_i,
   output logic [7:0] data_o
);
   assign data_o = SBOX[data_i];
endmodule

// File: rtl/subbytes_seq.sv
// SubBytes sequencer: captures a state, substitutes NUM_LANES bytes per cycle in place,
// then holds the result for downstream with back-pressure and zero-bubble hand-off.
module subbytes_seq
   import aes_pkg::*;
#(
   parameter int unsigned NUM_LANES = 1
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          clear,
   subbytes_seq_if.slave bus
);

   localparam logic [3:0] LAST_IDX = 4'(AES_NUM_BYTES - int'(NUM_LANES));
   localparam logic [3:0] IDX_STEP = 4'(NUM_LANES);

   subbytes_state_t        state_q, state_d;
   logic [3:0]             idx_q, idx_d;
   logic [AES_STATE_W-1:0] work_q, work_d;

   logic [3:0] lane_idx [NUM_LANES];
   logic [7:0] lane_in  [NUM_LANES];
   logic [7:0] lane_out [NUM_LANES];

   for (genvar k = 0; k < int'(NUM_LANES); k++) begin : g_lane
      assign lane_idx[k] = idx_q + 4'(k);
      assign lane_in[k]  = get_byte(work_q, lane_idx[k]);
      aes_sbox_lut u_sbox (
         .data_i(lane_in[k]),
         .data_o(lane_out[k])
      );
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      work_d  = work_q;
      if (clear) begin
         state_d = IDLE;
         idx_d   = '0;
         work_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  work_d  = bus.in_state;
                  idx_d   = '0;
                  state_d = SUB;
               end
            end
            SUB: begin
               for (int k = 0; k < int'(NUM_LANES); k++) begin
                  work_d = put_byte(work_d, lane_idx[k], lane_out[k]);
               end
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = HOLD;
               end else begin
                  idx_d = idx_q + IDX_STEP;
               end
            end
            HOLD: begin
               // A new state accepted on the output handshake edge starts SUB with no bubble.
               if (bus.out_ready) begin
                  if (bus.in_valid) begin
                     work_d  = bus.in_state;
                     idx_d   = '0;
                     state_d = SUB;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         work_q  <= work_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE) | ((state_q == HOLD) & bus.out_ready);
   assign bus.out_valid = (state_q == HOLD);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_state = work_q;

endmodule
